// File: rtl/load_data_align.sv
// Load data alignment unit: accepts one load request at a time, waits for the
// data-memory read word, extracts the addressed byte/halfword/word using
// big-endian byte lanes, extends it, and presents the result until consumed.
// Misaligned accesses and memory timeouts are reported as flagged results.
module load_data_align #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_opcode,
  input  logic [1:0]  req_addr_lo,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        load_valid,
  input  logic        load_ready,
  output logic [31:0] load_data,
  output logic        load_misaligned,
  output logic        load_timeout
);

  // Load opcodes shared with the decoder.
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    op_q, op_d;
  logic [1:0]    addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic          mis_q, mis_d;
  logic          to_q, to_d;

  logic is_load, is_mis;

  // Pick the addressed lane (offset 0 is the most significant byte) and extend.
  function automatic logic [31:0] extract(input logic [5:0] op,
                                          input logic [1:0] a,
                                          input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = a[1] ? w[15:0] : w[31:16];
    case (op)
      OP_LB:   r = {{24{b[7]}}, b};
      OP_LBU:  r = {24'd0, b};
      OP_LH:   r = {{16{h[15]}}, h};
      OP_LHU:  r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Classify the incoming request: recognised load, and alignment fault.
  always_comb begin
    is_load = (req_opcode == OP_LB) || (req_opcode == OP_LH) ||
              (req_opcode == OP_LW) || (req_opcode == OP_LBU) ||
              (req_opcode == OP_LHU);
    is_mis  = ((req_opcode == OP_LH || req_opcode == OP_LHU) && req_addr_lo[0]) ||
              ((req_opcode == OP_LW) && (req_addr_lo != 2'd0));
  end

  // Next-state logic: accept, wait for memory or timeout, hold result.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    data_d  = data_q;
    mis_d   = mis_q;
    to_d    = to_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && is_load) begin
          op_d   = req_opcode;
          addr_d = req_addr_lo;
          if (is_mis) begin
            state_d = S_RESP;
            data_d  = 32'd0;
            mis_d   = 1'b1;
            to_d    = 1'b0;
          end else begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end
        end
      end
      S_WAIT: begin
        // Data arriving on the last allowed cycle still wins over timeout.
        if (mem_rvalid) begin
          state_d = S_RESP;
          data_d  = extract(op_q, addr_q, mem_rdata);
          mis_d   = 1'b0;
          to_d    = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_RESP;
          data_d  = 32'd0;
          mis_d   = 1'b0;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        if (load_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset dropping any in-flight request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      mis_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mis_q   <= mis_d;
      to_q    <= to_d;
    end
  end

  assign req_ready       = (state_q == S_IDLE);
  assign load_valid      = (state_q == S_RESP);
  assign load_data       = data_q;
  assign load_misaligned = mis_q;
  assign load_timeout    = to_q;

endmodule

// File: tb/tb_load_data_align.sv
// Directed bench for load_data_align: table of extraction/misalignment
// vectors plus hand-written timeout, backpressure, reset and non-load cases.
module tb_load_data_align;

  localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24, LHU = 6'h25, SB = 6'h28;
  localparam logic [31:0] RD = 32'h812345F6;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [5:0]  req_opcode;
  logic [1:0]  req_addr_lo;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        load_valid, load_ready;
  logic [31:0] load_data;
  logic        load_misaligned, load_timeout;

  int checks = 0;
  int errors = 0;

  load_data_align #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_addr_lo(req_addr_lo),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_misaligned(load_misaligned),
    .load_timeout(load_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [1:0]  addr;
    logic [31:0] rdata;
    logic [31:0] exp_data;
    logic        exp_mis;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic [5:0] op, input logic [1:0] a);
    req_valid = 1'b1; req_opcode = op; req_addr_lo = a;
    step();
    req_valid = 1'b0;
  endtask

  task automatic consume();
    load_ready = 1'b1;
    step();
    load_ready = 1'b0;
    chk("back_to_idle_ready", {31'd0, req_ready}, 32'd1);
    chk("back_to_idle_valid", {31'd0, load_valid}, 32'd0);
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_valid"}, {31'd0, load_valid}, 32'd0);
    chk({tag, "_data"}, load_data, 32'd0);
    chk({tag, "_flags"}, {30'd0, load_misaligned, load_timeout}, 32'd0);
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{LB,  2'd0, RD, 32'hFFFFFF81, 1'b0};
    vecs[1]  = '{LBU, 2'd3, RD, 32'h000000F6, 1'b0};
    vecs[2]  = '{LH,  2'd0, RD, 32'hFFFF8123, 1'b0};
    vecs[3]  = '{LHU, 2'd0, RD, 32'h00008123, 1'b0};
    vecs[4]  = '{LH,  2'd2, RD, 32'h000045F6, 1'b0};
    vecs[5]  = '{LW,  2'd0, RD, 32'h812345F6, 1'b0};
    vecs[6]  = '{LW,  2'd1, RD, 32'h00000000, 1'b1};
    vecs[7]  = '{LH,  2'd3, RD, 32'h00000000, 1'b1};
    vecs[8]  = '{LB,  2'd1, RD, 32'h00000023, 1'b0};
    vecs[9]  = '{LB,  2'd3, RD, 32'hFFFFFFF6, 1'b0};
    vecs[10] = '{LHU, 2'd2, 32'hFFFF9ABC, 32'h00009ABC, 1'b0};
    vecs[11] = '{LBU, 2'd1, 32'h00A50000, 32'h000000A5, 1'b0};

    rst = 1'b1; req_valid = 1'b0; req_opcode = '0; req_addr_lo = '0;
    mem_rdata = '0; mem_rvalid = 1'b0; load_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    chk_idle_zero("reset");

    // Table: extraction and misalignment
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].addr);
      if (vecs[i].exp_mis) begin
        // Result available immediately, without any memory response.
        chk("mis_valid", {31'd0, load_valid}, 32'd1);
        chk("mis_flag", {31'd0, load_misaligned}, 32'd1);
      end else begin
        chk("wait_valid", {31'd0, load_valid}, 32'd0);
        chk("wait_ready", {31'd0, req_ready}, 32'd0);
        mem_rvalid = 1'b1; mem_rdata = vecs[i].rdata;
        step();
        mem_rvalid = 1'b0;
        chk("resp_valid", {31'd0, load_valid}, 32'd1);
        chk("resp_mis", {31'd0, load_misaligned}, 32'd0);
      end
      chk($sformatf("vec%0d_data", i), load_data, vecs[i].exp_data);
      chk("vec_timeout", {31'd0, load_timeout}, 32'd0);
      consume();
    end

    // Timeout after 4 WAIT cycles, late data ignored
    issue(LW, 2'd0);
    step(); step(); step();
    chk("to_not_yet", {31'd0, load_valid}, 32'd0);
    step();
    chk("to_valid", {31'd0, load_valid}, 32'd1);
    chk("to_flag", {31'd0, load_timeout}, 32'd1);
    chk("to_mis", {31'd0, load_misaligned}, 32'd0);
    chk("to_data", load_data, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = RD;
    step();
    chk("to_late_data", load_data, 32'd0);
    chk("to_late_flag", {31'd0, load_timeout}, 32'd1);
    consume();
    step();
    mem_rvalid = 1'b0;
    chk("idle_ignores_rvalid", {31'd0, load_valid}, 32'd0);
    issue(LW, 2'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    step();
    mem_rvalid = 1'b0;
    chk("after_to_data", load_data, 32'hCAFEF00D);
    chk("after_to_flag", {31'd0, load_timeout}, 32'd0);
    consume();

    // Data on the final WAIT cycle beats timeout
    issue(LBU, 2'd2);
    step(); step(); step();
    mem_rvalid = 1'b1; mem_rdata = RD;
    step();
    mem_rvalid = 1'b0;
    chk("prio_data", load_data, 32'h00000045);
    chk("prio_flag", {31'd0, load_timeout}, 32'd0);
    consume();

    // Backpressure for 5 cycles
    issue(LH, 2'd0);
    mem_rvalid = 1'b1; mem_rdata = RD;
    step();
    mem_rvalid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("bp_data", load_data, 32'hFFFF8123);
      chk("bp_valid", {31'd0, load_valid}, 32'd1);
      chk("bp_ready", {31'd0, req_ready}, 32'd0);
      step();
    end
    consume();

    // Reset mid-WAIT: no result for the dropped request
    issue(LW, 2'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle_zero("rst_wait");
    mem_rvalid = 1'b1; mem_rdata = RD;
    step();
    mem_rvalid = 1'b0;
    chk("rst_wait_no_valid", {31'd0, load_valid}, 32'd0);
    step();
    chk("rst_wait_no_valid2", {31'd0, load_valid}, 32'd0);

    // Reset mid-RESP clears the held result
    issue(LW, 2'd2);
    chk("pre_rst_mis", {31'd0, load_misaligned}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle_zero("rst_resp");

    // Non-load opcode is ignored
    req_valid = 1'b1; req_opcode = SB; req_addr_lo = 2'd0;
    step(); step();
    req_valid = 1'b0;
    chk("sb_ready", {31'd0, req_ready}, 32'd1);
    chk("sb_valid", {31'd0, load_valid}, 32'd0);
    mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0;
    chk("sb_valid2", {31'd0, load_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_data_align.md
LOAD_DATA_ALIGN -- requirements
Module: load_data_align

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, default 255, number of WAIT cycles without mem_rvalid before a timeout response.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: req_valid  input  1  load request present.
REQ-005 SHALL have port: req_ready  output  1  block can accept a request.
REQ-006 SHALL have port: req_opcode  input  6  instruction opcode, using the LB/LH/LW/LBU/LHU codes from the shared opcode header.
REQ-007 SHALL have port: req_addr_lo  input  2  effective address bits [1:0].
REQ-008 SHALL have port: mem_rdata  input  32  raw data-memory read word.
REQ-009 SHALL have port: mem_rvalid  input  1  mem_rdata valid this cycle.
REQ-010 SHALL have port: load_valid  output  1  load result available.
REQ-011 SHALL have port: load_ready  input  1  consumer accepts result.
REQ-012 SHALL have port: load_data  output  32  aligned, extended load result.
REQ-013 SHALL have port: load_misaligned  output  1  result is an alignment fault.
REQ-014 SHALL have port: load_timeout  output  1  result is a memory timeout.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 SHALL drive req_ready=1 only in IDLE; load_valid=1 only in RESP.
REQ-017 SHALL capture req_opcode and req_addr_lo on req_valid&req_ready.
REQ-018 SHALL ignore accepted requests whose opcode is not LB/LH/LW/LBU/LHU; FSM stays IDLE.
REQ-019 SHALL treat LH/LHU with addr_lo[0]=1, and LW with addr_lo!=0, as misaligned: IDLE->RESP next cycle, load_data=0, load_misaligned=1; no memory wait.
REQ-020 SHALL otherwise go IDLE->WAIT and clear the wait counter.
REQ-021 SHALL use big-endian byte lanes: offset 0 = bits [31:24], 1 = [23:16], 2 = [15:8], 3 = [7:0]; halfword offset 0 = [31:16], 2 = [15:0].
REQ-022 SHALL sign-extend for LB/LH and zero-extend for LBU/LHU; LW passes the full word.
REQ-023 SHALL, in WAIT, on mem_rvalid=1 register the extracted result, clear both flags, and move to RESP; load_valid rises the cycle after mem_rvalid (latency 1).
REQ-024 SHALL increment the wait counter each WAIT cycle with mem_rvalid=0.
REQ-025 SHALL, when the counter reaches TIMEOUT_CYCLES-1 with mem_rvalid=0, go to RESP with load_data=0 and load_timeout=1.
REQ-026 SHALL give mem_rvalid priority over timeout in the same cycle.
REQ-027 SHALL hold load_data and both flags stable in RESP until load_valid&load_ready, then return to IDLE the next cycle.
REQ-028 SHALL ignore mem_rvalid in IDLE and RESP, including late data after a timeout.
REQ-029 SHALL keep load_misaligned and load_timeout mutually exclusive.

Reset
REQ-030 SHALL, on rst=1 at a clock edge in any state, enter IDLE, clear the counter and captured fields, and drive load_valid=0, load_data=0, load_misaligned=0, load_timeout=0, req_ready=1 from the next cycle.
REQ-031 SHALL discard any in-flight request on reset mid-WAIT or mid-RESP; no result is produced for it.

Verification
REQ-032 SHALL verify extraction with mem_rdata=32'h812345F6 and 1-cycle memory: LB@0 -> 32'hFFFFFF81; LBU@3 -> 32'h000000F6; LH@0 -> 32'hFFFF8123; LHU@0 -> 32'h00008123; LH@2 -> 32'h000045F6; LW@0 -> 32'h812345F6.
REQ-033 SHALL verify misalignment: LW@1 -> RESP next cycle, load_misaligned=1, load_data=0, mem_rvalid never consulted; same for LH@3.
REQ-034 SHALL verify timeout with TIMEOUT_CYCLES=4 and no mem_rvalid -> load_timeout=1, load_data=0 after 4 WAIT cycles; a later mem_rvalid is ignored and the next LW returns correct data.
REQ-035 SHALL verify backpressure: load_ready=0 for 5 cycles in RESP -> load_data stable, req_ready=0; load_ready=1 -> IDLE and req_ready=1 the next cycle.
REQ-036 SHALL verify reset mid-WAIT: rst pulsed after request -> outputs zero, IDLE; subsequent mem_rvalid produces no load_valid.
REQ-037 SHALL verify a non-load opcode (e.g. SB) with req_valid=1 -> no state change, load_valid stays 0.
